// File: rtl/sync_pulse_gen_if.sv
// Bundle of the sync_pulse_gen control inputs and pulse/status outputs.
// The master side drives en/arm/ext_sync/period. The slave side (the generator) drives the rest.
interface sync_pulse_gen_if #(
    parameter int PERIOD_WIDTH = 16,
    parameter int COUNT_WIDTH  = 32
) ();
    logic                    en;
    logic                    arm;
    logic                    ext_sync;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    sync_out;
    logic [COUNT_WIDTH-1:0]  sync_count;
    logic [1:0]              state_o;
    logic                    period_err;

    modport master (
        output en, arm, ext_sync, period,
        input  sync_out, sync_count, state_o, period_err
    );

    modport slave (
        input  en, arm, ext_sync, period,
        output sync_out, sync_count, state_o, period_err
    );
endinterface

// File: rtl/sync_pulse_gen.sv
// Phase-locked periodic sync pulse generator feeding a sync_delay chain.
// Optional macro SYNC_GEN_EXT_CHECK_EN adds a sticky phase-error checker on ext_sync.
module sync_pulse_gen #(
    parameter int PERIOD_WIDTH = 16,
    parameter int PULSE_WIDTH  = 1,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    sync_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] P_ONE   = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] P_MIN   = PERIOD_WIDTH'(2);
    localparam logic [COUNT_WIDTH-1:0]  C_ONE   = COUNT_WIDTH'(1);
    localparam bit                      PW_FITS = (64'(PULSE_WIDTH) >> PERIOD_WIDTH) == 64'd0;
    localparam logic [PERIOD_WIDTH-1:0] PW_P    = PW_FITS ? PERIOD_WIDTH'(PULSE_WIDTH) : '1;

    function automatic logic [PERIOD_WIDTH-1:0] clamp_period(input logic [PERIOD_WIDTH-1:0] p);
        return (p < P_MIN) ? P_MIN : p;
    endfunction

    // Keeps sync_out low for at least one cycle of every period.
    function automatic logic [PERIOD_WIDTH-1:0] clamp_pulse(input logic [PERIOD_WIDTH-1:0] p);
        logic [PERIOD_WIDTH-1:0] lim;
        lim = p - P_ONE;
        return (PW_P < lim) ? PW_P : lim;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + C_ONE;
    endfunction

    state_t                  state, state_n;
    logic [PERIOD_WIDTH-1:0] period_q, period_n;
    logic [PERIOD_WIDTH-1:0] pw_q, pw_n;
    logic [PERIOD_WIDTH-1:0] phase, phase_n;
    logic                    sync_q, sync_n;
    logic [COUNT_WIDTH-1:0]  count_q, count_n;
    logic                    ext_sync_d;
    logic                    ext_edge;

    assign ext_edge = bus.ext_sync & ~ext_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // en dominates arm, arm dominates whatever the current state would do.
    always_comb begin
        state_n  = state;
        period_n = period_q;
        pw_n     = pw_q;
        phase_n  = '0;
        sync_n   = 1'b0;
        count_n  = count_q;
        if (!bus.en) begin
            state_n = IDLE;
        end else if (bus.arm) begin
            state_n  = ARMED;
            period_n = clamp_period(bus.period);
            pw_n     = clamp_pulse(period_n);
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                ARMED: begin
                    if (ext_edge) begin
                        state_n = RUN;
                        sync_n  = 1'b1;
                        count_n = sat_inc(count_q);
                    end
                end
                RUN: begin
                    phase_n = (phase == period_q - P_ONE) ? '0 : phase + P_ONE;
                    sync_n  = (phase_n < pw_q);
                    if (phase_n == '0) begin
                        count_n = sat_inc(count_q);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q   <= '0;
            pw_q       <= '0;
            phase      <= '0;
            sync_q     <= 1'b0;
            count_q    <= '0;
            ext_sync_d <= 1'b0;
        end else begin
            period_q   <= period_n;
            pw_q       <= pw_n;
            phase      <= phase_n;
            sync_q     <= sync_n;
            count_q    <= count_n;
            ext_sync_d <= bus.ext_sync;
        end
    end

`ifdef SYNC_GEN_EXT_CHECK_EN
    logic err_q, err_n;

    // The reference edge should land on the last phase so it coincides with our next pulse.
    always_comb begin
        err_n = err_q;
        if (bus.en && bus.arm) begin
            err_n = 1'b0;
        end else if (bus.en && (state == RUN) && ext_edge && (phase != period_q - P_ONE)) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_n;
        end
    end

    assign bus.period_err = err_q;
`else
    assign bus.period_err = 1'b0;
`endif

    assign bus.sync_out   = sync_q;
    assign bus.sync_count = count_q;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_sync_pulse_gen.sv
// Scoreboard bench for sync_pulse_gen: three instances with different pulse/count widths share one stimulus stream.
// Expected values are queued per sample cycle and compared by an independent negedge monitor.
module tb_sync_pulse_gen;
    logic        clk;
    logic        rst;
    logic        en;
    logic        arm;
    logic        ext_sync;
    logic [15:0] period;

    int edges;
    int checks;
    int failures;
    int ph;
    bit done;

`ifdef SYNC_GEN_EXT_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    typedef struct {
        int          dut;
        int          sig;
        int          at;
        int          tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    sync_pulse_gen_if #(.PERIOD_WIDTH(16), .COUNT_WIDTH(4))  bus0 ();
    sync_pulse_gen_if #(.PERIOD_WIDTH(16), .COUNT_WIDTH(32)) bus1 ();
    sync_pulse_gen_if #(.PERIOD_WIDTH(16), .COUNT_WIDTH(32)) bus2 ();

    assign bus0.en = en;  assign bus0.arm = arm;  assign bus0.ext_sync = ext_sync;  assign bus0.period = period;
    assign bus1.en = en;  assign bus1.arm = arm;  assign bus1.ext_sync = ext_sync;  assign bus1.period = period;
    assign bus2.en = en;  assign bus2.arm = arm;  assign bus2.ext_sync = ext_sync;  assign bus2.period = period;

    sync_pulse_gen #(.PERIOD_WIDTH(16), .PULSE_WIDTH(1), .COUNT_WIDTH(4)) u0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    sync_pulse_gen #(.PERIOD_WIDTH(16), .PULSE_WIDTH(3), .COUNT_WIDTH(32)) u1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );
    sync_pulse_gen #(.PERIOD_WIDTH(16), .PULSE_WIDTH(4), .COUNT_WIDTH(32)) u2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    function automatic logic [31:0] actual(input int d, input int s);
        logic [31:0] v;
        v = '0;
        if (d == 0) begin
            case (s)
                0: v = 32'(bus0.sync_out);
                1: v = 32'(bus0.sync_count);
                2: v = 32'(bus0.state_o);
                default: v = 32'(bus0.period_err);
            endcase
        end else if (d == 1) begin
            case (s)
                0: v = 32'(bus1.sync_out);
                1: v = bus1.sync_count;
                2: v = 32'(bus1.state_o);
                default: v = 32'(bus1.period_err);
            endcase
        end else begin
            case (s)
                0: v = 32'(bus2.sync_out);
                1: v = bus2.sync_count;
                2: v = 32'(bus2.state_o);
                default: v = 32'(bus2.period_err);
            endcase
        end
        return v;
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            0: return "sync_out";
            1: return "sync_count";
            2: return "state_o";
            default: return "period_err";
        endcase
    endfunction

    function automatic void push(input int d, input int s, input int at, input logic [31:0] v);
        exp_t e;
        e.dut = d; e.sig = s; e.at = at; e.tag = ph; e.val = v;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].at <= edges) begin
            e = sb.pop_front();
            checks++;
            if (e.at < edges) begin
                failures++;
                $display("FAIL p%0d_%s dut%0d cycle %0d: sample missed (now %0d) required %0h",
                         e.tag, sig_name(e.sig), e.dut, e.at, edges, e.val);
            end else begin
                got = actual(e.dut, e.sig);
                if (got !== e.val) begin
                    failures++;
                    $display("FAIL p%0d_%s dut%0d cycle %0d: got %0h required %0h",
                             e.tag, sig_name(e.sig), e.dut, e.at, got, e.val);
                end
            end
        end
        if (done) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL p%0d_%s dut%0d cycle %0d: never sampled, required %0h",
                         e.tag, sig_name(e.sig), e.dut, e.at, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; arm = 1'b0; ext_sync = 1'b0; period = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int s;
        edges = 0; checks = 0; failures = 0; done = 1'b0; ph = 0;
        rst = 1'b1; en = 1'b0; arm = 1'b0; ext_sync = 1'b0; period = '0;
        // reset values
        push(0, 0, 2, 0); push(0, 1, 2, 0); push(0, 2, 2, 0); push(0, 3, 2, 0);
        push(2, 1, 2, 0);
        step(3);
        rst = 1'b0;
        step(1);

        // lock and free-run, period 8, pulse width 1
        ph = 1; b = edges;
        push(0, 2, b+1, 1);
        push(0, 0, b+3, 0); push(0, 2, b+3, 1);
        push(0, 0, b+4, 1); push(0, 1, b+4, 1); push(0, 2, b+4, 2);
        push(0, 0, b+5, 0);
        push(0, 0, b+11, 0);
        push(0, 0, b+12, 1); push(0, 1, b+12, 2);
        push(0, 0, b+20, 1); push(0, 1, b+20, 3);
        en = 1'b1; arm = 1'b1; period = 16'd8;
        step(1);
        arm = 1'b0;
        step(2);
        ext_sync = 1'b1;
        step(20);

        // period 0 clamps to 2, pulse width 3 clamps to 1
        ph = 2; b = edges;
        push(1, 0, b+1, 0); push(1, 2, b+1, 1);
        push(1, 0, b+2, 1); push(1, 2, b+2, 2);
        push(1, 0, b+3, 0); push(1, 0, b+4, 1); push(1, 0, b+5, 0);
        period = 16'd0; arm = 1'b1; ext_sync = 1'b0;
        step(1);
        arm = 1'b0; ext_sync = 1'b1;
        step(6);

        // period 4 with pulse width 3
        ph = 3; b = edges;
        push(1, 0, b+2, 1); push(1, 0, b+3, 1); push(1, 0, b+4, 1);
        push(1, 0, b+5, 0); push(1, 0, b+6, 1);
        period = 16'd4; arm = 1'b1; ext_sync = 1'b0;
        step(1);
        arm = 1'b0; ext_sync = 1'b1;
        step(7);

        // re-arm mid-pulse, then en drop and arm/edge collisions
        ph = 4;
        do_reset();
        b = edges;
        push(2, 0, b+2, 1);  push(2, 1, b+2, 1);  push(2, 2, b+2, 2);
        push(2, 0, b+3, 1);
        push(2, 0, b+4, 0);  push(2, 1, b+4, 1);  push(2, 2, b+4, 1);
        push(2, 0, b+5, 0);  push(2, 2, b+5, 1);
        push(2, 0, b+6, 1);  push(2, 1, b+6, 2);  push(2, 2, b+6, 2);
        push(2, 0, b+7, 1);
        push(2, 0, b+8, 0);  push(2, 1, b+8, 2);  push(2, 2, b+8, 0);
        push(2, 0, b+10, 0); push(2, 2, b+10, 1);
        push(2, 0, b+11, 0); push(2, 1, b+11, 2); push(2, 2, b+11, 1);
        push(2, 2, b+12, 0);
        en = 1'b1; arm = 1'b1; period = 16'd10;
        step(1);
        arm = 1'b0; ext_sync = 1'b1;
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0; ext_sync = 1'b0;
        step(1);
        ext_sync = 1'b1;
        step(2);
        en = 1'b0;
        step(1);
        ext_sync = 1'b0;
        step(1);
        en = 1'b1; arm = 1'b1; ext_sync = 1'b1;
        step(1);
        arm = 1'b0;
        step(1);
        en = 1'b0; arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(2);

        // 4-bit counter saturation, then async reset between edges
        ph = 5;
        do_reset();
        b = edges;
        s = b + 2;
        push(0, 1, s, 1);
        push(0, 1, s+26, 14);
        push(0, 1, s+28, 15);
        push(0, 0, s+38, 1); push(0, 1, s+38, 15);
        push(0, 0, s+40, 0); push(0, 1, s+40, 0); push(0, 2, s+40, 0);
        en = 1'b1; period = 16'd2; arm = 1'b1;
        step(1);
        arm = 1'b0; ext_sync = 1'b1;
        step(41);
        #2;
        rst = 1'b1;
        step(2);
        rst = 1'b0;

        // ext phase checker, period 8
        ph = 6;
        do_reset();
        b = edges;
        s = b + 2;
        push(0, 0, s, 1);     push(0, 1, s, 1);     push(0, 3, s, 0);
        push(0, 0, s+8, 1);   push(0, 1, s+8, 2);
        push(0, 3, s+9, 0);
        push(0, 3, s+11, 0);
        push(0, 3, s+12, EXP_ERR);
        push(0, 3, s+16, EXP_ERR);
        push(0, 3, s+17, 0);  push(0, 2, s+17, 1);
        en = 1'b1; period = 16'd8; arm = 1'b1;
        step(1);
        arm = 1'b0; ext_sync = 1'b1;
        step(2);
        ext_sync = 1'b0;
        step(6);
        ext_sync = 1'b1;
        step(2);
        ext_sync = 1'b0;
        step(2);
        ext_sync = 1'b1;
        step(5);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        step(3);

        done = 1'b1;
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
